// File: rtl/timer_counter_pkg.sv
// Shared register map, CTRL layout, MODE codes and FSM encodings for the timer
// block and the bus bridge that selects it.
package timer_counter_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
  localparam logic [31:0] OFF_PRESET = 32'h0000_0004;
  localparam logic [31:0] OFF_COUNT  = 32'h0000_0008;

  // Implemented CTRL width; the packed field order fixes bit positions:
  // bit0 EN, bits[2:1] MODE, bit3 IM.
  localparam int CTRL_W = 4;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Codes 1x behave as one-shot, so only the exact reload code reloads.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// CPU data-bus slice seen by the timer: word address, write strobe/data and
// combinational read data.
interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a maskable
// interrupt; three word registers at BASE_ADDR.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic             clk,
  input  logic             reset,
  timer_counter_if.slave   bus,
  output logic             irq
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q;
  logic        irq_flag_q;
  state_e      state_q;

  logic [31:0] offset;
  logic        sel_ctrl, sel_preset, sel_count;
  logic        wr_ctrl, wr_preset;
  logic        fsm_clr_en;
  logic        unused_addr_bits;

  // Byte-lane bits are ignored; BASE_ADDR is word-aligned.
  assign offset           = {bus.addr[31:2], 2'b00} - BASE_ADDR;
  assign unused_addr_bits = ^bus.addr[1:0];

  assign sel_ctrl   = (offset == OFF_CTRL);
  assign sel_preset = (offset == OFF_PRESET);
  assign sel_count  = (offset == OFF_COUNT);

  assign wr_ctrl    = bus.we && sel_ctrl;
  assign wr_preset  = bus.we && sel_preset;

  always_comb begin
    bus.rdata = '0;
    if (sel_ctrl)        bus.rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
    else if (sel_preset) bus.rdata = preset_q;
    else if (sel_count)  bus.rdata = count_q;
  end

  assign fsm_clr_en = (state_q == ST_INT) && !is_reload(ctrl_q.mode);

  // A CPU write to CTRL takes precedence over the one-shot EN clear.
  always_comb begin
    ctrl_d = ctrl_q;
    if (fsm_clr_en) ctrl_d.en = 1'b0;
    if (wr_ctrl)    ctrl_d = ctrl_t'(bus.wdata[CTRL_W-1:0]);
  end

  assign preset_d = wr_preset ? bus.wdata : preset_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_q.en) begin
            irq_flag_q <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          // Terminal count at 1 (or 0) so PRESET 0/1 both expire immediately.
          if (!ctrl_q.en) begin
            state_q <= ST_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= ST_INT;
          end
        end
        ST_INT: begin
          if (is_reload(ctrl_q.mode)) irq_flag_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized bench for timer_counter against an elapsed-time
// reference model of the counter.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7f00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  timer_counter_if bus_if ();

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_if),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: registers plus 'age' = edges since the counter was armed
  // (-1 when not running); the count is derived from the latched load value.
  logic        m_en, m_im;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, m_load;
  logic        m_flag;
  int          m_age;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:2] == A_CTRL[31:2])   return {28'd0, m_im, m_mode, m_en};
    if (a[31:2] == A_PRESET[31:2]) return m_preset;
    if (a[31:2] == A_COUNT[31:2])  return m_count;
    return 32'd0;
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit   drop_en;
    int   span;
    logic old_en;
    logic [1:0] old_mode;
    drop_en  = 0;
    old_en   = m_en;
    old_mode = m_mode;
    if (r) begin
      m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0; m_flag = 0; m_age = -1;
      return;
    end
    span = (m_load <= 32'd1) ? 1 : int'(m_load);
    if (m_age < 0) begin
      if (old_en) begin m_flag = 0; m_age = 0; end
    end else if (m_age == 0) begin
      m_load  = m_preset;
      m_count = m_load;
      m_age   = 1;
    end else if (m_age <= ((m_load <= 32'd1) ? 1 : int'(m_load))) begin
      if (!old_en) m_age = -1;
      else if (m_age < span) begin m_count = m_load - 32'(m_age); m_age++; end
      else begin m_count = 0; m_flag = 1; m_age++; end
    end else begin
      if (old_mode == 2'b01) m_flag = 0;
      else drop_en = 1;
      m_age = -1;
    end
    if (w && a[31:2] == A_CTRL[31:2]) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
    end else if (drop_en) m_en = 0;
    if (w && a[31:2] == A_PRESET[31:2]) m_preset = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    #1;
    chk(tag, bus_if.rdata, exp);
  endtask

  // One clock: drive, edge, update model, then compare irq and COUNT/CTRL.
  task automatic tick(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    rst          = r;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    cyc++;
    #1;
    rst       = 1'b0;
    bus_if.we = 1'b0;
    chk("irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    rd_chk("count", A_COUNT, m_count);
    rd_chk("ctrl", A_CTRL, m_read(A_CTRL));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int pulses[$];
  logic [31:0] ra, rv;
  int sel;

  initial begin
    m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0; m_load = 0; m_flag = 0; m_age = -1;
    bus_if.we = 0; bus_if.addr = 0; bus_if.wdata = 0;

    // Reset state.
    tick(1, 0, 32'h0, 32'h0);
    tick(1, 0, 32'h0, 32'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_preset", A_PRESET, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // One-shot, PRESET=5, CTRL=0x9.
    tick(0, 1, A_PRESET, 32'd5);
    tick(0, 1, A_CTRL, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 32'h0, 32'h0);
      if (k == 1) rd_chk("os_count_k1", A_COUNT, 32'd0);
      if (k == 2) rd_chk("os_count_k2", A_COUNT, 32'd5);
      if (k == 6) chk("os_irq_k6", {31'd0, irq}, 32'd0);
      if (k == 7) chk("os_irq_k7", {31'd0, irq}, 32'd1);
      if (k == 7) rd_chk("os_count_k7", A_COUNT, 32'd0);
      if (k == 8) rd_chk("os_ctrl_k8", A_CTRL, 32'h8);
    end
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    tick(0, 1, A_CTRL, 32'h9);
    tick(0, 0, 32'h0, 32'h0);
    chk("os_irq_cleared", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3, CTRL=0xB.
    tick(1, 0, 32'h0, 32'h0);
    tick(0, 1, A_PRESET, 32'd3);
    tick(0, 1, A_CTRL, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      tick(0, 0, 32'h0, 32'h0);
      if (irq === 1'b1) pulses.push_back(k);
    end
    chk("ar_npulses", 32'(pulses.size()), 32'd4);
    if (pulses.size() == 4) begin
      chk("ar_first", 32'(pulses[0]), 32'd5);
      for (int i = 1; i < 4; i++) chk("ar_period", 32'(pulses[i] - pulses[i-1]), 32'd6);
    end
    tick(0, 1, A_CTRL, 32'h0);
    idle(3);

    // Mask: completes silently, unmasking shows the held flag.
    tick(1, 0, 32'h0, 32'h0);
    tick(0, 1, A_PRESET, 32'd2);
    tick(0, 1, A_CTRL, 32'h1);
    idle(8);
    chk("mask_irq0", {31'd0, irq}, 32'd0);
    rd_chk("mask_ctrl", A_CTRL, 32'h0);
    tick(0, 1, A_CTRL, 32'h8);
    chk("mask_irq1", {31'd0, irq}, 32'd1);

    // Pause at COUNT=4, then resume with reload.
    tick(1, 0, 32'h0, 32'h0);
    tick(0, 1, A_PRESET, 32'd10);
    tick(0, 1, A_CTRL, 32'h9);
    idle(7);
    rd_chk("pause_pre", A_COUNT, 32'd5);
    tick(0, 1, A_CTRL, 32'h8);
    idle(3);
    rd_chk("pause_frozen", A_COUNT, 32'd4);
    tick(0, 1, A_CTRL, 32'h9);
    idle(2);
    rd_chk("pause_reload", A_COUNT, 32'd10);

    // Boundaries.
    tick(1, 0, 32'h0, 32'h0);
    tick(0, 1, A_CTRL, 32'h9);
    idle(2);
    chk("p0_irq_e2", {31'd0, irq}, 32'd0);
    idle(1);
    chk("p0_irq_e3", {31'd0, irq}, 32'd1);
    tick(0, 1, A_COUNT, 32'h1234);
    rd_chk("count_ro", A_COUNT, 32'd0);
    rd_chk("oow_read", BASE + 32'hC, 32'd0);
    rd_chk("low_bits_ignored", BASE + 32'h1, 32'h8);
    tick(0, 1, A_CTRL, 32'hFFFF_FFFF);
    rd_chk("ctrl_mask", A_CTRL, 32'hF);
    idle(4);

    // Reset mid-count; a PRESET write during the run leaves the count alone.
    tick(1, 0, 32'h0, 32'h0);
    tick(0, 1, A_PRESET, 32'd20);
    tick(0, 1, A_CTRL, 32'h9);
    for (int k = 1; k <= 15; k++) begin
      if (k == 10) tick(0, 1, A_PRESET, 32'd99);
      else         tick(0, 0, 32'h0, 32'h0);
    end
    rd_chk("rmc_count7", A_COUNT, 32'd7);
    tick(1, 1, A_CTRL, 32'hF);
    rd_chk("rmc_ctrl", A_CTRL, 32'h0);
    rd_chk("rmc_preset", A_PRESET, 32'h0);
    rd_chk("rmc_count", A_COUNT, 32'h0);
    chk("rmc_irq", {31'd0, irq}, 32'd0);
    idle(3);
    rd_chk("rmc_idle", A_COUNT, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2)       tick(1, $urandom_range(0, 1) != 0, A_CTRL, $urandom);
      else if (sel < 10) tick(0, 1, A_CTRL, {$urandom_range(0, 1) != 0 ? 32'hFFFF_FFF0 : 32'h0} | 32'($urandom_range(0, 15)) | 32'($urandom_range(0, 2) != 0));
      else if (sel < 16) tick(0, 1, A_PRESET, 32'($urandom_range(0, 7)));
      else if (sel < 19) begin
        ra = ($urandom_range(0, 1) != 0) ? A_COUNT + 32'($urandom_range(0, 3)) : $urandom;
        tick(0, 1, ra, $urandom);
      end else tick(0, 0, $urandom, $urandom);
      rd_chk("rnd_preset", A_PRESET, m_read(A_PRESET));
      ra = ($urandom_range(0, 3) == 0) ? BASE + 32'($urandom_range(0, 31)) : $urandom;
      rv = m_read(ra);
      rd_chk("rnd_read", ra, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
